fetch_prefetch_unit: RTL

Parametrised instruction-fetch stage for the ARM pipeline. It replaces the single-register IF stage with a fetch engine that drives an instruction-memory handshake and keeps a DEPTH-entry prefetch queue. It supports branch redirect/flush and hazard freeze. It sits between instruction memory and the IF/ID pipeline register and presents {pc+step, inst} to decode.

---
 rtl/fetch_prefetch_unit.sv | 103 ++++++++++
 1 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch engine with a DEPTH-entry prefetch queue, branch flush and hazard hold; optional FETCH_STATS_EN counters.
// Latency: an instruction accepted with mem_ready in cycle t reaches out_* in cycle t+1.
// Backpressure: hazard holds the head; mem_req drops only when the queue is full.
module fetch_prefetch_unit #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH = 4,
  parameter int PC_STEP = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       branch_taken,
  input  logic [ADDR_W-1:0]          branch_addr,
  input  logic                       hazard,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_ready,
  input  logic [INST_W-1:0]          mem_rdata,
  output logic                       out_valid,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [INST_W-1:0]          out_inst,
  output logic [$clog2(DEPTH):0]     occupancy
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]                stat_fetched,
  output logic [31:0]                stat_flushes,
  output logic [31:0]                stat_stall_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0] fetch_pc;
  logic              full;
  logic              push;
  logic              pop;

  assign full      = (occupancy == FULL_CNT);
  // rst gating keeps the request low while reset is held, even though the queue reads empty
  assign mem_req   = !rst && !full;
  assign mem_addr  = fetch_pc;
  assign out_valid = (occupancy != '0);
  assign push      = mem_req && mem_ready && !branch_taken;
  assign pop       = out_valid && !hazard && !branch_taken;
  assign out_pc    = out_valid ? (addr_mem[rd_ptr] + ADDR_W'(PC_STEP)) : '0;
  assign out_inst  = out_valid ? inst_mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else if (branch_taken) begin
      fetch_pc  <= branch_addr;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // queue storage needs no reset: entries are only read once occupancy covers them
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= fetch_pc;
      inst_mem[wr_ptr] <= mem_rdata;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_fetched      <= '0;
      stat_flushes      <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (push)                stat_fetched      <= stat_fetched + 1'b1;
      if (branch_taken)        stat_flushes      <= stat_flushes + 1'b1;
      if (out_valid && hazard) stat_stall_cycles <= stat_stall_cycles + 1'b1;
    end
  end
`endif

endmodule
